// File: rtl/l1_rd_arbiter_pkg.sv
// rtl/l1_rd_arbiter_pkg.sv - shared state, grant and burst encodings for the L1 read arbiter
package l1_rd_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  localparam logic GNT_IL1 = 1'b0;
  localparam logic GNT_DL1 = 1'b1;

  localparam logic [1:0] INCR = 2'b01;

endpackage

// File: rtl/l1_rd_arbiter_arb_sel.sv
// rtl/l1_rd_arbiter_arb_sel.sv - winner select; ARB_RR_EN adds a round-robin last-grant flop
module l1_rd_arbiter_arb_sel
  import l1_rd_arbiter_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic grant_en,
`endif
  input  logic il1_req,
  input  logic dl1_req,
  output logic win
);

`ifdef ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_gnt <= GNT_IL1;
    else if (grant_en)
      last_gnt <= win;
  end

  // On contention the master that did not win last time goes first.
  always_comb begin
    if (il1_req && dl1_req)
      win = ~last_gnt;
    else if (dl1_req)
      win = GNT_DL1;
    else
      win = GNT_IL1;
  end
`else
  assign win = dl1_req ? GNT_DL1 : GNT_IL1;
`endif

endmodule

// File: rtl/l1_rd_arbiter.sv
// rtl/l1_rd_arbiter.sv - shares one L2 AXI read port between IL1 and DL1 refills (ARB_RR_EN: round-robin)
module l1_rd_arbiter
  import l1_rd_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] IL1_ARADDR,
  input  logic [7:0]    IL1_ARLEN,
  input  logic [1:0]    IL1_ARBURST,
  input  logic          IL1_ARVALID,
  output logic          IL1_ARREADY,
  output logic [DW-1:0] IL1_RDATA,
  output logic [1:0]    IL1_RRESP,
  output logic          IL1_RLAST,
  output logic          IL1_RVALID,
  input  logic          IL1_RREADY,
  input  logic [AW-1:0] DL1_ARADDR,
  input  logic [7:0]    DL1_ARLEN,
  input  logic [1:0]    DL1_ARBURST,
  input  logic          DL1_ARVALID,
  output logic          DL1_ARREADY,
  output logic [DW-1:0] DL1_RDATA,
  output logic [1:0]    DL1_RRESP,
  output logic          DL1_RLAST,
  output logic          DL1_RVALID,
  input  logic          DL1_RREADY,
  output logic [AW-1:0] L2_ARADDR,
  output logic [7:0]    L2_ARLEN,
  output logic [1:0]    L2_ARBURST,
  output logic          L2_ARVALID,
  input  logic          L2_ARREADY,
  input  logic [DW-1:0] L2_RDATA,
  input  logic [1:0]    L2_RRESP,
  input  logic          L2_RLAST,
  input  logic          L2_RVALID,
  output logic          L2_RREADY,
  output logic          arb_busy,
  output logic          arb_err
);

  logic [1:0]    state;
  logic          gnt;
  logic          win;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [1:0]    ar_burst;
  logic [7:0]    len_q;
  logic [7:0]    beat_cnt;
  logic          err_q;

  logic any_req, in_addr, in_data, il1_sel, dl1_sel, r_hs;

  assign any_req = IL1_ARVALID | DL1_ARVALID;
  assign in_addr = (state == ARB_ADDR);
  assign in_data = (state == ARB_DATA);
  assign il1_sel = in_data & (gnt == GNT_IL1);
  assign dl1_sel = in_data & (gnt == GNT_DL1);
  assign r_hs    = L2_RVALID & L2_RREADY;

  l1_rd_arbiter_arb_sel u_arb_sel (
`ifdef ARB_RR_EN
    .clk      (CLK),
    .rst      (RST),
    .grant_en ((state == ARB_IDLE) & any_req),
`endif
    .il1_req  (IL1_ARVALID),
    .dl1_req  (DL1_ARVALID),
    .win      (win)
  );

  assign L2_ARVALID  = in_addr;
  assign L2_ARADDR   = ar_addr;
  assign L2_ARLEN    = ar_len;
  assign L2_ARBURST  = ar_burst;
  assign IL1_ARREADY = in_addr & L2_ARREADY & (gnt == GNT_IL1);
  assign DL1_ARREADY = in_addr & L2_ARREADY & (gnt == GNT_DL1);

  // Read channel is a straight pass-through to the granted master only.
  assign L2_RREADY  = (il1_sel & IL1_RREADY) | (dl1_sel & DL1_RREADY);
  assign IL1_RVALID = il1_sel & L2_RVALID;
  assign IL1_RDATA  = il1_sel ? L2_RDATA : '0;
  assign IL1_RRESP  = il1_sel ? L2_RRESP : 2'b00;
  assign IL1_RLAST  = il1_sel & L2_RLAST;
  assign DL1_RVALID = dl1_sel & L2_RVALID;
  assign DL1_RDATA  = dl1_sel ? L2_RDATA : '0;
  assign DL1_RRESP  = dl1_sel ? L2_RRESP : 2'b00;
  assign DL1_RLAST  = dl1_sel & L2_RLAST;

  assign arb_busy = (state != ARB_IDLE);
  assign arb_err  = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ARB_IDLE;
      gnt      <= GNT_IL1;
      ar_addr  <= '0;
      ar_len   <= 8'd0;
      ar_burst <= 2'b00;
      len_q    <= 8'd0;
      beat_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            gnt      <= win;
            ar_addr  <= (win == GNT_DL1) ? DL1_ARADDR  : IL1_ARADDR;
            ar_len   <= (win == GNT_DL1) ? DL1_ARLEN   : IL1_ARLEN;
            ar_burst <= (win == GNT_DL1) ? DL1_ARBURST : IL1_ARBURST;
            state    <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (L2_ARREADY) begin
            len_q    <= ar_len;
            beat_cnt <= 8'd0;
            state    <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // A short burst flags on RLAST; a long one flags when it overruns len.
            if (L2_RLAST) begin
              if (beat_cnt != len_q)
                err_q <= 1'b1;
              state <= ARB_IDLE;
            end else if (beat_cnt == len_q) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_rd_arbiter.sv
// tb/tb_l1_rd_arbiter.sv - randomized self-checking bench for l1_rd_arbiter
module tb_l1_rd_arbiter;
  import l1_rd_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [1:0]    burst;
  } req_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] IL1_ARADDR, DL1_ARADDR, L2_ARADDR;
  logic [7:0]    IL1_ARLEN, DL1_ARLEN, L2_ARLEN;
  logic [1:0]    IL1_ARBURST, DL1_ARBURST, L2_ARBURST;
  logic          IL1_ARVALID, DL1_ARVALID, L2_ARVALID;
  logic          IL1_ARREADY, DL1_ARREADY, L2_ARREADY;
  logic [DW-1:0] IL1_RDATA, DL1_RDATA, L2_RDATA;
  logic [1:0]    IL1_RRESP, DL1_RRESP, L2_RRESP;
  logic          IL1_RLAST, DL1_RLAST, L2_RLAST;
  logic          IL1_RVALID, DL1_RVALID, L2_RVALID;
  logic          IL1_RREADY, DL1_RREADY, L2_RREADY;
  logic          arb_busy, arb_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_err  = 1'b0;
  logic exp_last = GNT_IL1;

  l1_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST),
    .IL1_ARADDR(IL1_ARADDR), .IL1_ARLEN(IL1_ARLEN), .IL1_ARBURST(IL1_ARBURST),
    .IL1_ARVALID(IL1_ARVALID), .IL1_ARREADY(IL1_ARREADY),
    .IL1_RDATA(IL1_RDATA), .IL1_RRESP(IL1_RRESP), .IL1_RLAST(IL1_RLAST),
    .IL1_RVALID(IL1_RVALID), .IL1_RREADY(IL1_RREADY),
    .DL1_ARADDR(DL1_ARADDR), .DL1_ARLEN(DL1_ARLEN), .DL1_ARBURST(DL1_ARBURST),
    .DL1_ARVALID(DL1_ARVALID), .DL1_ARREADY(DL1_ARREADY),
    .DL1_RDATA(DL1_RDATA), .DL1_RRESP(DL1_RRESP), .DL1_RLAST(DL1_RLAST),
    .DL1_RVALID(DL1_RVALID), .DL1_RREADY(DL1_RREADY),
    .L2_ARADDR(L2_ARADDR), .L2_ARLEN(L2_ARLEN), .L2_ARBURST(L2_ARBURST),
    .L2_ARVALID(L2_ARVALID), .L2_ARREADY(L2_ARREADY),
    .L2_RDATA(L2_RDATA), .L2_RRESP(L2_RRESP), .L2_RLAST(L2_RLAST),
    .L2_RVALID(L2_RVALID), .L2_RREADY(L2_RREADY),
    .arb_busy(arb_busy), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] addr, input int beat);
    return {addr, 32'(beat) ^ 32'h5a5a_5a5a};
  endfunction

  task automatic clear_inputs();
    IL1_ARVALID = 0; IL1_ARADDR = '0; IL1_ARLEN = 0; IL1_ARBURST = 0; IL1_RREADY = 0;
    DL1_ARVALID = 0; DL1_ARADDR = '0; DL1_ARLEN = 0; DL1_ARBURST = 0; DL1_RREADY = 0;
    L2_ARREADY = 0; L2_RDATA = '0; L2_RRESP = 0; L2_RLAST = 0; L2_RVALID = 0;
  endtask

  // nbo: 0 = well-formed burst, >0 = exact beat count, -1 = random short, -2 = one beat long.
  task automatic serve(input logic w, input req_t r, input int ar_dly, input int nbo, input bit bp);
    int nb, got, cyc;
    logic vld, rdy;
    @(negedge CLK);
    check_eq("l2_arvalid_rise", L2_ARVALID, 1);
    check_eq("l2_araddr", L2_ARADDR, r.addr);
    check_eq("l2_arlen", L2_ARLEN, r.len);
    check_eq("l2_arburst", L2_ARBURST, r.burst);
    check_eq("busy_addr", arb_busy, 1);
    for (int d = 0; d < ar_dly; d++) begin
      L2_ARREADY = 1'b0;
      #1;
      check_eq("arready_early", {IL1_ARREADY, DL1_ARREADY}, 0);
      @(negedge CLK);
      check_eq("l2_ar_hold", {L2_ARVALID, L2_ARADDR, L2_ARLEN}, {1'b1, r.addr, r.len});
    end
    L2_ARREADY = 1'b1;
    #1;
    check_eq("arready_win", w ? DL1_ARREADY : IL1_ARREADY, 1);
    check_eq("arready_lose", w ? IL1_ARREADY : DL1_ARREADY, 0);
    @(negedge CLK);
    #1;
    check_eq("arready_pulse", {IL1_ARREADY, DL1_ARREADY, L2_ARVALID}, 0);
    L2_ARREADY = 1'b0;
    if (w) DL1_ARVALID = 1'b0; else IL1_ARVALID = 1'b0;

    if (nbo == -1 && r.len > 0) nb = $urandom_range(int'(r.len), 1);
    else if (nbo == -2)         nb = int'(r.len) + 2;
    else if (nbo > 0)           nb = nbo;
    else                        nb = int'(r.len) + 1;

    got = 0;
    cyc = 0;
    while (got < nb && cyc < 400) begin
      vld = ($urandom_range(3) != 0);
      rdy = ($urandom_range(3) != 0);
      if (bp && cyc >= 2 && cyc < 5) begin
        vld = 1'b1;
        rdy = 1'b0;
      end
      L2_RVALID = vld;
      L2_RDATA  = data_of(r.addr, got);
      L2_RRESP  = got[1:0];
      L2_RLAST  = (got == nb - 1);
      if (w) begin DL1_RREADY = rdy; IL1_RREADY = 1'($urandom_range(1)); end
      else   begin IL1_RREADY = rdy; DL1_RREADY = 1'($urandom_range(1)); end
      #1;
      check_eq("rvalid_win", w ? DL1_RVALID : IL1_RVALID, vld);
      check_eq("rdata_win", w ? DL1_RDATA : IL1_RDATA, data_of(r.addr, got));
      check_eq("rresp_win", w ? DL1_RRESP : IL1_RRESP, got[1:0]);
      check_eq("rlast_win", w ? DL1_RLAST : IL1_RLAST, (got == nb - 1));
      check_eq("l2_rready", L2_RREADY, rdy);
      check_eq("r_lose", w ? {IL1_RVALID, IL1_RDATA} : {DL1_RVALID, DL1_RDATA}, 0);
      @(negedge CLK);
      if (vld && rdy) got++;
      cyc++;
    end
    if (got < nb) check_eq("beat_timeout", got, nb);
    L2_RVALID = 0; L2_RLAST = 0; IL1_RREADY = 0; DL1_RREADY = 0;
    if (nb != int'(r.len) + 1) exp_err = 1'b1;
    #1;
    check_eq("idle_after_last", {arb_busy, L2_ARVALID}, 0);
    check_eq("arb_err", arb_err, exp_err);
  endtask

  task automatic do_round(input bit want_il1, input bit want_dl1, input req_t ri, input req_t rd,
                          input int ar_dly, input int nbo, input bit bp);
    bit   pi, pd;
    logic w;
    @(negedge CLK);
    IL1_ARVALID = want_il1; IL1_ARADDR = ri.addr; IL1_ARLEN = ri.len; IL1_ARBURST = ri.burst;
    DL1_ARVALID = want_dl1; DL1_ARADDR = rd.addr; DL1_ARLEN = rd.len; DL1_ARBURST = rd.burst;
    pi = want_il1;
    pd = want_dl1;
    while (pi || pd) begin
      if (pi && pd) begin
`ifdef ARB_RR_EN
        w = ~exp_last;
`else
        w = GNT_DL1;
`endif
      end else begin
        w = pd;
      end
      exp_last = w;
      serve(w, w ? rd : ri, ar_dly, nbo, bp);
      if (w) pd = 0; else pi = 0;
      nbo = 0;
      bp  = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t ri, rd;
    int   sel;
    clear_inputs();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("rst_outputs", {L2_ARVALID, L2_ARADDR, L2_RREADY, IL1_ARREADY, DL1_ARREADY,
                             IL1_RVALID, DL1_RVALID, arb_busy, arb_err}, 0);
    RST = 1'b0;

    ri = '{32'h8000_0100, 8'd3, INCR};
    rd = '{32'h4000_0200, 8'd3, INCR};
    do_round(1, 0, ri, rd, 2, 0, 0);
    do_round(1, 1, ri, rd, 1, 0, 0);
    do_round(1, 1, ri, rd, 0, 0, 0);
    rd.len = 8'd5;
    do_round(0, 1, ri, rd, 0, 0, 1);
    rd.len = 8'd3;
    do_round(0, 1, ri, rd, 1, 2, 0);
    do_round(1, 0, ri, rd, 0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ri.addr  = $urandom & 32'hffff_ffc0;
      rd.addr  = ri.addr ^ 32'h0001_0000;
      ri.len   = 8'($urandom_range(7));
      rd.len   = 8'($urandom_range(7));
      ri.burst = 2'($urandom_range(2));
      rd.burst = INCR;
      sel = $urandom_range(9);
      case ($urandom_range(2))
        0:       do_round(1, 0, ri, rd, $urandom_range(3), (sel == 0) ? -1 : (sel == 1) ? -2 : 0, 0);
        1:       do_round(0, 1, ri, rd, $urandom_range(3), (sel == 0) ? -1 : (sel == 1) ? -2 : 0, 0);
        default: do_round(1, 1, ri, rd, $urandom_range(3), (sel == 0) ? -1 : (sel == 1) ? -2 : 0, 0);
      endcase
      repeat ($urandom_range(2)) @(negedge CLK);
    end

    // Abandon a burst with reset right after its first beat.
    @(negedge CLK);
    IL1_ARVALID = 1; IL1_ARADDR = 32'h8000_0200; IL1_ARLEN = 8'd3; IL1_ARBURST = INCR;
    @(negedge CLK);
    L2_ARREADY = 1;
    @(negedge CLK);
    L2_ARREADY = 0; IL1_ARVALID = 0;
    L2_RVALID = 1; IL1_RREADY = 1; L2_RDATA = '1; L2_RLAST = 0;
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check_eq("rst_async", {arb_busy, arb_err, IL1_RVALID, IL1_RDATA, L2_RREADY, L2_ARVALID, L2_ARADDR}, 0);
    exp_err  = 1'b0;
    exp_last = GNT_IL1;
    @(negedge CLK);
    clear_inputs();
    RST = 1'b0;
    ri = '{32'h8000_0300, 8'd1, INCR};
    do_round(1, 0, ri, rd, 0, 0, 0);
    do_round(1, 1, ri, rd, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_rd_arbiter.md
Name: l1_rd_arbiter

Overview:
- Shares one L2/memory AXI read port between the IL1 and DL1 cache refill masters.
- Sits between the icache/dcache AXI read channels and the L2 interconnect.
- Grants one master per burst, forwards AR, and routes R beats back to the granted master until RLAST.
- Counts beats and flags any burst-length mismatch.

Parameters:
- AW, 32, AXI address width.
- DW, 64, AXI read data width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- IL1_ARADDR  in  AW  icache burst address.
- IL1_ARLEN  in  8  icache burst length minus 1.
- IL1_ARBURST  in  2  icache burst type.
- IL1_ARVALID  in  1  icache request valid.
- IL1_ARREADY  out  1  icache request accepted.
- IL1_RDATA  out  DW  read data to icache.
- IL1_RRESP  out  2  response to icache.
- IL1_RLAST  out  1  last beat to icache.
- IL1_RVALID  out  1  beat valid to icache.
- IL1_RREADY  in  1  icache beat ready.
- DL1_ARADDR / DL1_ARLEN / DL1_ARBURST / DL1_ARVALID  in  AW/8/2/1  dcache request, same meaning as IL1.
- DL1_ARREADY  out  1  dcache request accepted.
- DL1_RDATA / DL1_RRESP / DL1_RLAST / DL1_RVALID  out  DW/2/1/1  read channel to dcache.
- DL1_RREADY  in  1  dcache beat ready.
- L2_ARADDR / L2_ARLEN / L2_ARBURST / L2_ARVALID  out  AW/8/2/1  downstream request.
- L2_ARREADY  in  1  downstream accept.
- L2_RDATA / L2_RRESP / L2_RLAST / L2_RVALID  in  DW/2/1/1  downstream read data.
- L2_RREADY  out  1  downstream beat ready.
- arb_busy  out  1  a burst is granted (state != IDLE).
- arb_err  out  1  sticky: RLAST beat count != ARLEN+1.

Behaviour:
- Reset: asynchronous, active-high RST.
  - All outputs 0; state IDLE; grant none; beat counter 0; arb_err 0.
  - Reset mid-burst abandons the burst with no completion to either master.
- States: IDLE, ADDR, DATA (2-bit encoding).
- IDLE:
  - Any ARVALID high: latch grant, and register ARADDR/ARLEN/ARBURST from the winner into the L2 AR registers.
  - Go to ADDR; L2_ARVALID rises the next cycle. Request-to-L2 latency is 1 cycle.
- Arbitration without the macro: fixed priority, DL1 over IL1.
- ADDR:
  - L2_ARVALID held with stable payload until L2_ARVALID & L2_ARREADY.
  - In that same cycle, the granted master's ARREADY pulses for exactly 1 cycle; the other ARREADY stays 0.
  - Latch len = ARLEN and clear the beat counter; go to DATA.
- DATA:
  - Combinational routing: granted xx_RVALID = L2_RVALID; xx_RDATA/RRESP/RLAST = L2 values; L2_RREADY = granted xx_RREADY.
  - The ungranted master sees RVALID = 0 and RDATA = 0.
  - Each handshake (L2_RVALID & L2_RREADY) increments the 8-bit beat counter.
  - Handshake with L2_RLAST: set arb_err if counter != len; go to IDLE.
  - Handshake without RLAST while counter == len also sets arb_err; the block stays in DATA until RLAST.
- The earliest new grant is the cycle after the RLAST handshake; there is no back-to-back overlap.
- Masters must hold ARVALID and payload until ARREADY (AXI rule).
  - A requester dropping ARVALID before its grant is simply not granted.
  - Once latched, a grant is never revoked.
- Both ARVALID rising in the same cycle: exactly one is granted; the loser waits in IDLE arbitration after the burst.
- arb_err clears only on reset.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last-grant register (reset value = IL1) makes the non-last master win when both request.
  - The register updates on every grant.
- Undefined: fixed DL1 > IL1 priority with no last-grant register.

Decomposition:
- Shared package/define file holds:
  - state localparams ARB_IDLE=0, ARB_ADDR=1, ARB_DATA=2.
  - grant encodings GNT_IL1=0, GNT_DL1=1.
  - AXI burst constant INCR=2'b01.
- One natural sub-module: arb_sel. This is the combinational winner select plus, under ARB_RR_EN, the last-grant flop.
- Everything else is flat, using the existing gen_dffr/gen_rsffr-style register primitives.

Test Plan:
- Single IL1 request, ARADDR=0x8000_0100, ARLEN=3; L2_ARREADY after 2 cycles; 4 beats:
  - L2_ARVALID rises 1 cycle after IL1_ARVALID.
  - IL1_ARREADY pulses once, coincident with L2 accept.
  - IL1 sees 4 beats with RLAST on the 4th.
  - DL1_RVALID stays 0; arb_err=0.
- IL1 and DL1 rise in the same cycle, both ARLEN=3:
  - Without macro: DL1 is served first, then IL1 starting in the cycle after DL1's RLAST handshake.
  - With ARB_RR_EN from reset: DL1 is served first (last=IL1); a repeat simultaneous request then grants IL1.
- Backpressure: DL1_RREADY held 0 for 3 cycles mid-burst:
  - L2_RREADY = 0 in those cycles.
  - Beat counter frozen; no data lost.
- Protocol error: ARLEN=3 but L2_RLAST on beat 2:
  - arb_err = 1 sticky; state returns to IDLE.
  - The next request is still serviced.
- Reset asserted during DATA beat 1:
  - All outputs 0 asynchronously.
  - After release, a new IL1 request is granted normally.
